// File: rtl/cache_ctrl.sv
// Data-cache controller for one request port. It looks up the tag array and serves hits.
// Misses and uncached accesses go to the miss unit, and stores that hit are written into the array.
module cache_ctrl #(
  parameter logic [63:0] CACHE_START_ADDR   = 64'h8000_0000,
  parameter int unsigned DCACHE_SET_ASSOC   = 4,
  parameter int unsigned DCACHE_INDEX_WIDTH = 12,
  parameter int unsigned DCACHE_TAG_WIDTH   = 44,
  parameter int unsigned DCACHE_LINE_WIDTH  = 256
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        bypass_i,
  output logic                                        busy_o,
  // core request port
  input  logic [DCACHE_INDEX_WIDTH-1:0]               req_port_address_index_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]                 req_port_address_tag_i,
  input  logic                                        req_port_tag_valid_i,
  input  logic                                        req_port_data_req_i,
  input  logic                                        req_port_data_we_i,
  input  logic [7:0]                                  req_port_data_be_i,
  input  logic [1:0]                                  req_port_data_size_i,
  input  logic [63:0]                                 req_port_data_wdata_i,
  input  logic                                        req_port_kill_req_i,
  output logic                                        req_port_data_gnt_o,
  output logic                                        req_port_data_rvalid_o,
  output logic [63:0]                                 req_port_data_rdata_o,
  // tag/data array
  output logic [DCACHE_SET_ASSOC-1:0]                 req_o,
  output logic [DCACHE_INDEX_WIDTH-1:0]               addr_o,
  input  logic                                        gnt_i,
  input  logic [DCACHE_SET_ASSOC*DCACHE_LINE_WIDTH-1:0] data_i,
  input  logic [DCACHE_SET_ASSOC-1:0]                 hit_way_i,
  output logic [DCACHE_TAG_WIDTH-1:0]                 tag_o,
  output logic [DCACHE_LINE_WIDTH-1:0]                data_o,
  output logic                                        data_dirty_o,
  output logic                                        data_valid_o,
  output logic                                        we_o,
  output logic [DCACHE_LINE_WIDTH/8-1:0]              be_data_o,
  output logic [DCACHE_SET_ASSOC-1:0]                 be_vldrty_o,
  // miss unit
  output logic                                        miss_req_valid_o,
  output logic                                        miss_req_bypass_o,
  output logic [DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:0] miss_req_addr_o,
  output logic [7:0]                                  miss_req_be_o,
  output logic [1:0]                                  miss_req_size_o,
  output logic                                        miss_req_we_o,
  output logic [63:0]                                 miss_req_wdata_o,
  input  logic                                        miss_gnt_i,
  input  logic                                        active_serving_i,
  input  logic [63:0]                                 critical_word_i,
  input  logic                                        critical_word_valid_i,
  input  logic                                        bypass_gnt_i,
  input  logic                                        bypass_valid_i,
  input  logic [63:0]                                 bypass_data_i,
  output logic [DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:0] mshr_addr_o,
  input  logic                                        mshr_addr_matches_i,
  input  logic                                        mshr_index_matches_i
);

  localparam int unsigned PaddrWidth   = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
  localparam int unsigned ByteOffset   = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned WordsPerLine = DCACHE_LINE_WIDTH / 64;

  typedef enum logic [2:0] {
    StIdle, StWaitTag, StStoreReq, StWaitMshr, StWaitRefillGnt, StWaitCriticalWord,
    StWaitBypassValid
  } state_e;

  state_e                          state_q, state_d;
  logic [DCACHE_INDEX_WIDTH-1:0]   index_q, index_d;
  logic [DCACHE_TAG_WIDTH-1:0]     tag_q, tag_d;
  logic                            we_q, we_d;
  logic [7:0]                      be_q, be_d;
  logic [1:0]                      size_q, size_d;
  logic [63:0]                     wdata_q, wdata_d;
  logic [DCACHE_SET_ASSOC-1:0]     hit_way_q, hit_way_d;
  logic                            bypass_q, bypass_d;
  logic                            tag_saved_q, tag_saved_d;

  logic                            tag_valid_eff;
  logic [DCACHE_TAG_WIDTH-1:0]     tag_eff;
  logic [PaddrWidth-1:0]           paddr;
  logic                            uncached;
  logic [ByteOffset-4:0]           word_idx;
  logic [DCACHE_LINE_WIDTH-1:0]    hit_line;
  logic [WordsPerLine-1:0][63:0]   hit_words;
  logic [WordsPerLine-1:0][7:0]    be_words;
  logic                            store_phase;

  // After an MSHR stall the tag is already known, so the relookup does not wait for tag_valid.
  assign tag_valid_eff = tag_saved_q | req_port_tag_valid_i;
  assign tag_eff       = tag_saved_q ? tag_q : req_port_address_tag_i;
  assign tag_o         = (state_q == StWaitTag) ? tag_eff : tag_q;
  assign paddr         = {tag_o, index_q};
  assign mshr_addr_o   = paddr;
  assign uncached      = bypass_i | (64'(paddr) < CACHE_START_ADDR);
  assign word_idx      = index_q[ByteOffset-1:3];
  assign busy_o        = (state_q != StIdle);

  always_comb begin
    hit_line = '0;
    for (int w = 0; w < int'(DCACHE_SET_ASSOC); w++) begin
      if (hit_way_i[w]) hit_line |= data_i[w*DCACHE_LINE_WIDTH +: DCACHE_LINE_WIDTH];
    end
  end
  assign hit_words = hit_line;

  always_comb begin
    be_words           = '0;
    be_words[word_idx] = be_q;
  end

  assign store_phase  = (state_q == StStoreReq);
  assign data_o       = {WordsPerLine{wdata_q}};
  assign data_dirty_o = store_phase;
  assign data_valid_o = store_phase;
  assign be_data_o    = store_phase ? be_words : '0;
  assign be_vldrty_o  = store_phase ? hit_way_q : '0;

  assign miss_req_valid_o  = (state_q == StWaitRefillGnt);
  assign miss_req_bypass_o = bypass_q;
  assign miss_req_addr_o   = paddr;
  assign miss_req_be_o     = be_q;
  assign miss_req_size_o   = size_q;
  assign miss_req_we_o     = we_q;
  assign miss_req_wdata_o  = wdata_q;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    tag_d       = tag_q;
    we_d        = we_q;
    be_d        = be_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    hit_way_d   = hit_way_q;
    bypass_d    = bypass_q;
    tag_saved_d = tag_saved_q;
    req_o                  = '0;
    addr_o                 = index_q;
    we_o                   = 1'b0;
    req_port_data_gnt_o    = 1'b0;
    req_port_data_rvalid_o = 1'b0;
    req_port_data_rdata_o  = '0;

    unique case (state_q)
      StIdle: begin
        if (req_port_data_req_i) begin
          req_o  = '1;
          addr_o = req_port_address_index_i;
          if (gnt_i) begin
            req_port_data_gnt_o = 1'b1;
            index_d     = req_port_address_index_i;
            we_d        = req_port_data_we_i;
            be_d        = req_port_data_be_i;
            size_d      = req_port_data_size_i;
            wdata_d     = req_port_data_wdata_i;
            tag_saved_d = 1'b0;
            state_d     = StWaitTag;
          end
        end
      end
      StWaitTag: begin
        if (req_port_kill_req_i) begin
          req_port_data_rvalid_o = 1'b1;
          tag_saved_d            = 1'b0;
          state_d                = StIdle;
        end else if (tag_valid_eff) begin
          tag_d       = tag_eff;
          tag_saved_d = 1'b0;
          bypass_d    = uncached;
          if (uncached) begin
            state_d = StWaitRefillGnt;
          end else if (mshr_index_matches_i && active_serving_i) begin
            state_d = StWaitMshr;
          end else if (|hit_way_i) begin
            if (we_q) begin
              hit_way_d = hit_way_i;
              state_d   = StStoreReq;
            end else begin
              req_port_data_rvalid_o = 1'b1;
              req_port_data_rdata_o  = hit_words[word_idx];
              state_d                = StIdle;
            end
          end else begin
            state_d = StWaitRefillGnt;
          end
        end
      end
      StStoreReq: begin
        req_o = hit_way_q;
        we_o  = 1'b1;
        if (gnt_i) state_d = StIdle;
      end
      StWaitMshr: begin
        if (!mshr_index_matches_i) begin
          req_o = '1;
          if (gnt_i) begin
            tag_saved_d = 1'b1;
            state_d     = StWaitTag;
          end
        end
      end
      StWaitRefillGnt: begin
        if (bypass_q ? bypass_gnt_i : miss_gnt_i) begin
          if (we_q) state_d = StIdle;
          else state_d = bypass_q ? StWaitBypassValid : StWaitCriticalWord;
        end
      end
      StWaitCriticalWord: begin
        if (critical_word_valid_i) begin
          req_port_data_rvalid_o = 1'b1;
          req_port_data_rdata_o  = critical_word_i;
          state_d                = StIdle;
        end
      end
      StWaitBypassValid: begin
        if (bypass_valid_i) begin
          req_port_data_rvalid_o = 1'b1;
          req_port_data_rdata_o  = bypass_data_i;
          state_d                = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      index_q     <= '0;
      tag_q       <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      hit_way_q   <= '0;
      bypass_q    <= 1'b0;
      tag_saved_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      tag_q       <= tag_d;
      we_q        <= we_d;
      be_q        <= be_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      hit_way_q   <= hit_way_d;
      bypass_q    <= bypass_d;
      tag_saved_q <= tag_saved_d;
    end
  end

  // Line-level MSHR collisions are resolved by the index check above.
  logic unused_mshr_addr_match;
  assign unused_mshr_addr_match = mshr_addr_matches_i;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: hit, store, miss, bypass, kill, MSHR stall and async reset.
module tb_cache_ctrl;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          bypass_i;
  logic          busy_o;
  logic [11:0]   req_port_address_index_i;
  logic [43:0]   req_port_address_tag_i;
  logic          req_port_tag_valid_i, req_port_data_req_i, req_port_data_we_i;
  logic [7:0]    req_port_data_be_i;
  logic [1:0]    req_port_data_size_i;
  logic [63:0]   req_port_data_wdata_i;
  logic          req_port_kill_req_i;
  logic          req_port_data_gnt_o, req_port_data_rvalid_o;
  logic [63:0]   req_port_data_rdata_o;
  logic [3:0]    req_o;
  logic [11:0]   addr_o;
  logic          gnt_i;
  logic [1023:0] data_i;
  logic [3:0]    hit_way_i;
  logic [43:0]   tag_o;
  logic [255:0]  data_o;
  logic          data_dirty_o, data_valid_o, we_o;
  logic [31:0]   be_data_o;
  logic [3:0]    be_vldrty_o;
  logic          miss_req_valid_o, miss_req_bypass_o;
  logic [55:0]   miss_req_addr_o;
  logic [7:0]    miss_req_be_o;
  logic [1:0]    miss_req_size_o;
  logic          miss_req_we_o;
  logic [63:0]   miss_req_wdata_o;
  logic          miss_gnt_i, active_serving_i;
  logic [63:0]   critical_word_i;
  logic          critical_word_valid_i, bypass_gnt_i, bypass_valid_i;
  logic [63:0]   bypass_data_i;
  logic [55:0]   mshr_addr_o;
  logic          mshr_addr_matches_i, mshr_index_matches_i;

  int n_checks = 0;
  int n_fails  = 0;

  cache_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bypass_i(bypass_i), .busy_o(busy_o),
    .req_port_address_index_i(req_port_address_index_i),
    .req_port_address_tag_i(req_port_address_tag_i),
    .req_port_tag_valid_i(req_port_tag_valid_i), .req_port_data_req_i(req_port_data_req_i),
    .req_port_data_we_i(req_port_data_we_i), .req_port_data_be_i(req_port_data_be_i),
    .req_port_data_size_i(req_port_data_size_i), .req_port_data_wdata_i(req_port_data_wdata_i),
    .req_port_kill_req_i(req_port_kill_req_i), .req_port_data_gnt_o(req_port_data_gnt_o),
    .req_port_data_rvalid_o(req_port_data_rvalid_o),
    .req_port_data_rdata_o(req_port_data_rdata_o),
    .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i), .data_i(data_i), .hit_way_i(hit_way_i),
    .tag_o(tag_o), .data_o(data_o), .data_dirty_o(data_dirty_o), .data_valid_o(data_valid_o),
    .we_o(we_o), .be_data_o(be_data_o), .be_vldrty_o(be_vldrty_o),
    .miss_req_valid_o(miss_req_valid_o), .miss_req_bypass_o(miss_req_bypass_o),
    .miss_req_addr_o(miss_req_addr_o), .miss_req_be_o(miss_req_be_o),
    .miss_req_size_o(miss_req_size_o), .miss_req_we_o(miss_req_we_o),
    .miss_req_wdata_o(miss_req_wdata_o), .miss_gnt_i(miss_gnt_i),
    .active_serving_i(active_serving_i), .critical_word_i(critical_word_i),
    .critical_word_valid_i(critical_word_valid_i), .bypass_gnt_i(bypass_gnt_i),
    .bypass_valid_i(bypass_valid_i), .bypass_data_i(bypass_data_i),
    .mshr_addr_o(mshr_addr_o), .mshr_addr_matches_i(mshr_addr_matches_i),
    .mshr_index_matches_i(mshr_index_matches_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bypass_i = 1'b0; req_port_address_index_i = '0; req_port_address_tag_i = '0;
    req_port_tag_valid_i = 1'b0; req_port_data_req_i = 1'b0; req_port_data_we_i = 1'b0;
    req_port_data_be_i = '0; req_port_data_size_i = 2'd3; req_port_data_wdata_i = '0;
    req_port_kill_req_i = 1'b0; gnt_i = 1'b0; hit_way_i = '0; miss_gnt_i = 1'b0;
    active_serving_i = 1'b0; critical_word_i = '0; critical_word_valid_i = 1'b0;
    bypass_gnt_i = 1'b0; bypass_valid_i = 1'b0; bypass_data_i = '0;
    mshr_addr_matches_i = 1'b0; mshr_index_matches_i = 1'b0;
  endtask

  // Issue a request in IDLE with an immediate array grant; leaves the DUT in WAIT_TAG.
  task automatic issue(input logic [11:0] idx, input logic we, input logic [7:0] be,
                       input logic [63:0] wd);
    idle_inputs();
    req_port_data_req_i = 1'b1; req_port_address_index_i = idx; req_port_data_we_i = we;
    req_port_data_be_i = be; req_port_data_wdata_i = wd; gnt_i = 1'b1;
    settle();
    check("issue_gnt", 64'(req_port_data_gnt_o), 64'd1);
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    data_i = '0;
    data_i[1*256 + 2*64 +: 64] = 64'hDEAD_BEEF;
    data_i[1*256 + 0*64 +: 64] = 64'hCAFE;
    data_i[0*256 + 2*64 +: 64] = 64'h0BAD_0BAD;
    rst_ni = 1'b0;
    #2;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_req", 64'(req_o), 64'd0);
    check("rst_miss_valid", 64'(miss_req_valid_o), 64'd0);
    check("rst_rvalid", 64'(req_port_data_rvalid_o), 64'd0);
    check("rst_we", 64'(we_o), 64'd0);
    step();
    step();
    rst_ni = 1'b1;
    step();

    // No grant from the array: the request is held off.
    req_port_data_req_i = 1'b1; req_port_address_index_i = 12'h010;
    settle();
    check("nognt_req", 64'(req_o), 64'hF);
    check("nognt_gnt", 64'(req_port_data_gnt_o), 64'd0);
    step();
    check("nognt_busy", 64'(busy_o), 64'd0);
    idle_inputs();

    // Load hit at 0x8000_0010, way 1, word 2.
    req_port_data_req_i = 1'b1; req_port_address_index_i = 12'h010; gnt_i = 1'b1;
    settle();
    check("lh_addr", 64'(addr_o), 64'h010);
    step();
    idle_inputs();
    req_port_address_tag_i = 44'h80000; req_port_tag_valid_i = 1'b1; hit_way_i = 4'b0010;
    settle();
    check("lh_busy", 64'(busy_o), 64'd1);
    check("lh_tag", 64'(tag_o), 64'h80000);
    check("lh_rvalid", 64'(req_port_data_rvalid_o), 64'd1);
    check("lh_rdata", req_port_data_rdata_o, 64'hDEAD_BEEF);
    step();
    idle_inputs();
    settle();
    check("lh_done", 64'(busy_o), 64'd0);

    // Store hit at 0x8000_0008, be 0x0F, word 1.
    issue(12'h008, 1'b1, 8'h0F, 64'h1122_3344_5566_7788);
    req_port_address_tag_i = 44'h80000; req_port_tag_valid_i = 1'b1; hit_way_i = 4'b0010;
    settle();
    check("sh_no_rvalid", 64'(req_port_data_rvalid_o), 64'd0);
    step();
    idle_inputs();
    settle();
    check("sh_req", 64'(req_o), 64'b0010);
    check("sh_we", 64'(we_o), 64'd1);
    check("sh_addr", 64'(addr_o), 64'h008);
    check("sh_be", 64'(be_data_o), 64'h0000_0F00);
    check("sh_vldrty", 64'(be_vldrty_o), 64'b0010);
    check("sh_dirty", 64'(data_dirty_o), 64'd1);
    check("sh_wdata", data_o[127:64], 64'h1122_3344_5566_7788);
    step();
    check("sh_hold", 64'(we_o), 64'd1);
    gnt_i = 1'b1;
    settle();
    check("sh_gnt_no_rvalid", 64'(req_port_data_rvalid_o), 64'd0);
    step();
    idle_inputs();
    settle();
    check("sh_done", 64'(busy_o), 64'd0);

    // Load miss at 0x8000_0040.
    issue(12'h040, 1'b0, 8'hFF, 64'h0);
    req_port_address_tag_i = 44'h80000; req_port_tag_valid_i = 1'b1;
    step();
    idle_inputs();
    settle();
    check("lm_valid", 64'(miss_req_valid_o), 64'd1);
    check("lm_bypass", 64'(miss_req_bypass_o), 64'd0);
    check("lm_addr", 64'(miss_req_addr_o), 64'h8000_0040);
    check("lm_mshr_addr", 64'(mshr_addr_o), 64'h8000_0040);
    step();
    check("lm_valid_held", 64'(miss_req_valid_o), 64'd1);
    miss_gnt_i = 1'b1;
    step();
    idle_inputs();
    settle();
    check("lm_valid_drop", 64'(miss_req_valid_o), 64'd0);
    check("lm_wait_rvalid", 64'(req_port_data_rvalid_o), 64'd0);
    critical_word_i = 64'h1234; critical_word_valid_i = 1'b1;
    settle();
    check("lm_rvalid", 64'(req_port_data_rvalid_o), 64'd1);
    check("lm_rdata", req_port_data_rdata_o, 64'h1234);
    step();
    idle_inputs();
    settle();
    check("lm_done", 64'(busy_o), 64'd0);

    // Uncached load at 0x1000.
    issue(12'h000, 1'b0, 8'hFF, 64'h0);
    req_port_address_tag_i = 44'h1; req_port_tag_valid_i = 1'b1; hit_way_i = 4'b0001;
    settle();
    check("by_no_hit", 64'(req_port_data_rvalid_o), 64'd0);
    step();
    idle_inputs();
    settle();
    check("by_valid", 64'(miss_req_valid_o), 64'd1);
    check("by_bypass", 64'(miss_req_bypass_o), 64'd1);
    miss_gnt_i = 1'b1;
    step();
    check("by_ignores_miss_gnt", 64'(miss_req_valid_o), 64'd1);
    idle_inputs();
    bypass_gnt_i = 1'b1;
    step();
    idle_inputs();
    bypass_valid_i = 1'b1; bypass_data_i = 64'hAA;
    settle();
    check("by_rvalid", 64'(req_port_data_rvalid_o), 64'd1);
    check("by_rdata", req_port_data_rdata_o, 64'hAA);
    step();
    idle_inputs();

    // bypass_i forces a cacheable address uncached.
    issue(12'h010, 1'b0, 8'hFF, 64'h0);
    bypass_i = 1'b1; req_port_address_tag_i = 44'h80000; req_port_tag_valid_i = 1'b1;
    hit_way_i = 4'b0010;
    step();
    idle_inputs();
    settle();
    check("byi_bypass", 64'(miss_req_bypass_o), 64'd1);
    bypass_gnt_i = 1'b1;
    step();
    idle_inputs();
    bypass_valid_i = 1'b1;
    step();
    idle_inputs();

    // Kill in WAIT_TAG.
    issue(12'h010, 1'b0, 8'hFF, 64'h0);
    req_port_kill_req_i = 1'b1;
    settle();
    check("kill_rvalid", 64'(req_port_data_rvalid_o), 64'd1);
    step();
    idle_inputs();
    settle();
    check("kill_pulse", 64'(req_port_data_rvalid_o), 64'd0);
    check("kill_no_miss", 64'(miss_req_valid_o), 64'd0);
    check("kill_idle", 64'(busy_o), 64'd0);

    // MSHR index collision stalls, then the lookup is reissued with the saved tag.
    issue(12'h080, 1'b0, 8'hFF, 64'h0);
    req_port_address_tag_i = 44'h80000; req_port_tag_valid_i = 1'b1; hit_way_i = 4'b0010;
    mshr_index_matches_i = 1'b1; active_serving_i = 1'b1;
    settle();
    check("mshr_no_rvalid", 64'(req_port_data_rvalid_o), 64'd0);
    step();
    idle_inputs();
    mshr_index_matches_i = 1'b1; active_serving_i = 1'b1;
    settle();
    check("mshr_busy", 64'(busy_o), 64'd1);
    check("mshr_no_req", 64'(req_o), 64'd0);
    step();
    check("mshr_still", 64'(req_o), 64'd0);
    mshr_index_matches_i = 1'b0;
    settle();
    check("mshr_relookup", 64'(req_o), 64'hF);
    check("mshr_relookup_addr", 64'(addr_o), 64'h080);
    gnt_i = 1'b1;
    step();
    idle_inputs();
    hit_way_i = 4'b0010;
    settle();
    check("mshr_tag", 64'(tag_o), 64'h80000);
    check("mshr_rvalid", 64'(req_port_data_rvalid_o), 64'd1);
    check("mshr_rdata", req_port_data_rdata_o, 64'hCAFE);
    step();
    idle_inputs();

    // Asynchronous reset while a miss is outstanding.
    issue(12'h040, 1'b0, 8'hFF, 64'h0);
    req_port_address_tag_i = 44'h80000; req_port_tag_valid_i = 1'b1;
    step();
    idle_inputs();
    settle();
    check("ar_pre", 64'(miss_req_valid_o), 64'd1);
    rst_ni = 1'b0;
    settle();
    check("ar_miss_valid", 64'(miss_req_valid_o), 64'd0);
    check("ar_busy", 64'(busy_o), 64'd0);
    check("ar_mshr_addr", 64'(mshr_addr_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step();
    check("ar_no_rvalid", 64'(req_port_data_rvalid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
